// File: rtl/apb_pkg.sv
// Shared types, widths and helpers for the APB memory slave.
package apb_pkg;

    localparam int unsigned STRB_SIZE  = 2;
    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned MEM_DEPTH  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic [STRB_SIZE-1:0] {
        STRB_BYTE = 2'b00,
        STRB_HALF = 2'b01,
        STRB_WORD = 2'b10
    } strb_e;

    // Expand per-byte enables into a full-width data mask.
    function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [MEM_DEPTH-1:0] be);
        logic [DATA_WIDTH-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
            m[i*8 +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/apb_strb_decode.sv
// Byte-enable and error decode for an APB transfer request.
module apb_strb_decode
    import apb_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic [STRB_SIZE-1:0]  strobe,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [MEM_DEPTH-1:0]  be,
    output logic                  err
);

    // Lane selection from size/offset; flag misalignment, reserved size and out-of-range words.
    always_comb begin
        be  = '0;
        err = 1'b0;
        case (strobe)
            STRB_BYTE: be = 4'b0001 << addr[1:0];
            STRB_HALF: begin
                be  = 4'b0011 << addr[1:0];
                err = addr[0];
            end
            STRB_WORD: begin
                be  = '1;
                err = (addr[1:0] != 2'b00);
            end
            default:   err = 1'b1;
        endcase
        if (ADDR_WIDTH'(addr[ADDR_WIDTH-1:2]) >= ADDR_WIDTH'(MEM_WORDS)) begin
            err = 1'b1;
        end
    end

endmodule

// File: rtl/apb_mem_slave.sv
// APB slave in front of a synchronous word memory with fixed wait states.
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned MEM_WORDS   = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sel,
    input  logic                  enable,
    input  logic                  write,
    input  logic [STRB_SIZE-1:0]  strobe,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ready,
    output logic                  slverr,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_wr,
    output logic [MEM_DEPTH-1:0]  mem_be,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic                  err_q, err_d;
    logic [MEM_DEPTH-1:0]  be_q, be_d;
    logic [ADDR_WIDTH-3:0] word_q, word_d;

    logic [MEM_DEPTH-1:0]  dec_be;
    logic                  dec_err;

    logic                  ready_d, slverr_d, mem_wr_d;
    logic [DATA_WIDTH-1:0] rdata_d, mem_data_in_d;
    logic [MEM_DEPTH-1:0]  mem_be_d;
    logic [ADDR_WIDTH-1:0] mem_address_d;

    apb_strb_decode #(
        .MEM_WORDS(MEM_WORDS)
    ) u_decode (
        .strobe(strobe),
        .addr  (addr),
        .be    (dec_be),
        .err   (dec_err)
    );

    // Next-state, capture and next-output logic; outputs are computed for the state being entered.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        write_d       = write_q;
        err_d         = err_q;
        be_d          = be_q;
        word_d        = word_q;
        ready_d       = 1'b0;
        slverr_d      = 1'b0;
        rdata_d       = '0;
        mem_wr_d      = 1'b0;
        mem_be_d      = '0;
        mem_address_d = '0;
        mem_data_in_d = '0;
        case (state_q)
            IDLE: begin
                if (sel && !enable) begin
                    state_d       = ACCESS;
                    cnt_d         = 4'(WAIT_STATES - 1);
                    write_d       = write;
                    err_d         = dec_err;
                    be_d          = dec_be;
                    word_d        = addr[ADDR_WIDTH-1:2];
                    mem_be_d      = dec_err ? '0 : dec_be;
                    mem_address_d = {addr[ADDR_WIDTH-1:2], 2'b00};
                    mem_wr_d      = write && !dec_err;
                    mem_data_in_d = (write && !dec_err) ? wdata : '0;
                end
            end
            ACCESS: begin
                if (!sel || !enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    mem_be_d      = err_q ? '0 : be_q;
                    mem_address_d = {word_q, 2'b00};
                    if (cnt_q == 4'd0) begin
                        // Last ACCESS edge: read data is stable since mem_address was set one cycle earlier.
                        state_d  = RESP;
                        ready_d  = 1'b1;
                        slverr_d = err_q;
                        rdata_d  = (write_q || err_q) ? '0 : (mem_data_out & lane_mask(be_q));
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, wait counter and captured transfer attributes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            be_q    <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            err_q   <= err_d;
            be_q    <= be_d;
            word_q  <= word_d;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready       <= 1'b0;
            slverr      <= 1'b0;
            rdata       <= '0;
            mem_wr      <= 1'b0;
            mem_be      <= '0;
            mem_address <= '0;
            mem_data_in <= '0;
        end else begin
            ready       <= ready_d;
            slverr      <= slverr_d;
            rdata       <= rdata_d;
            mem_wr      <= mem_wr_d;
            mem_be      <= mem_be_d;
            mem_address <= mem_address_d;
            mem_data_in <= mem_data_in_d;
        end
    end

endmodule

// File: tb/tb_apb_mem_slave.sv
// Self-checking bench for apb_mem_slave: one instance with 2 wait states, one with 15.
module tb_apb_mem_slave;

    localparam int W0 = 2;
    localparam int W1 = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_clr = 1'b1;

    logic        sel_v[2], en_v[2], wr_v[2];
    logic [1:0]  strb_v[2];
    logic [31:0] addr_v[2], wdata_v[2];
    logic        ready_v[2], slverr_v[2], mem_wr_v[2];
    logic [31:0] rdata_v[2], maddr_v[2], mdin_v[2], mdout_v[2];
    logic [3:0]  mbe_v[2];

    bit [31:0] ref_mem[2][1024];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [31:0] mem[1024];

        apb_mem_slave #(
            .WAIT_STATES((g == 0) ? W0 : W1),
            .MEM_WORDS  (1024)
        ) dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .sel         (sel_v[g]),
            .enable      (en_v[g]),
            .write       (wr_v[g]),
            .strobe      (strb_v[g]),
            .addr        (addr_v[g]),
            .wdata       (wdata_v[g]),
            .ready       (ready_v[g]),
            .slverr      (slverr_v[g]),
            .rdata       (rdata_v[g]),
            .mem_wr      (mem_wr_v[g]),
            .mem_be      (mbe_v[g]),
            .mem_address (maddr_v[g]),
            .mem_data_in (mdin_v[g]),
            .mem_data_out(mdout_v[g])
        );

        // Memory attached to the slave: byte-enabled write, one-cycle read latency.
        always @(posedge clk) begin
            if (mem_clr) begin
                for (int i = 0; i < 1024; i++) mem[i] <= '0;
            end else begin
                if (mem_wr_v[g]) begin
                    for (int b = 0; b < 4; b++)
                        if (mbe_v[g][b]) mem[maddr_v[g][11:2]][b*8 +: 8] <= mdin_v[g][b*8 +: 8];
                end
                mdout_v[g] <= mem[maddr_v[g][11:2]];
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input int d, input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %h expected %h", tag, d, obs, exp);
        end
    endtask

    task automatic chk_zero(input int d, input string tag);
        chk(d, {tag, "_ready"},  32'(ready_v[d]),  0);
        chk(d, {tag, "_slverr"}, 32'(slverr_v[d]), 0);
        chk(d, {tag, "_rdata"},  rdata_v[d],       0);
        chk(d, {tag, "_mem_wr"}, 32'(mem_wr_v[d]), 0);
        chk(d, {tag, "_mem_be"}, 32'(mbe_v[d]),    0);
        chk(d, {tag, "_maddr"},  maddr_v[d],       0);
        chk(d, {tag, "_mdin"},   mdin_v[d],        0);
    endtask

    // Transfer rules: size = 2^strobe bytes, must be naturally aligned and inside the memory.
    function automatic void model(input bit [1:0] s, input bit [31:0] a,
                                  output bit [3:0] be, output bit err);
        int unsigned size;
        size = 1 << s;
        err  = (s == 2'd3) || ((a % size) != 0) || ((a / 4) >= 1024);
        be   = (s == 2'd3) ? 4'b0 : 4'(((1 << size) - 1) << (a % 4));
    endfunction

    // One APB transfer; abort_k > 0 drops sel/enable during that ACCESS cycle.
    task automatic xfer(input int d, input bit wr, input bit [1:0] s, input bit [31:0] a,
                        input bit [31:0] wd, input int abort_k);
        int        w;
        bit [3:0]  be;
        bit        err;
        bit        exp_wr;
        bit [31:0] word;
        bit [31:0] exp_rd;
        w = (d == 0) ? W0 : W1;
        model(s, a, be, err);
        exp_wr = wr && !err;
        word   = ref_mem[d][a[11:2]];
        exp_rd = '0;
        if (!wr && !err)
            for (int b = 0; b < 4; b++) if (be[b]) exp_rd[b*8 +: 8] = word[b*8 +: 8];

        sel_v[d] = 1'b1; en_v[d] = 1'b0; wr_v[d] = wr;
        strb_v[d] = s; addr_v[d] = a; wdata_v[d] = wd;
        @(posedge clk); #1;
        en_v[d] = 1'b1;
        for (int k = 1; k <= w; k++) begin
            chk(d, "access_ready", 32'(ready_v[d]), 0);
            chk(d, "access_be",    32'(mbe_v[d]),   err ? 32'd0 : 32'(be));
            chk(d, "access_addr",  maddr_v[d],      {a[31:2], 2'b00});
            if (k == 1) begin
                chk(d, "mem_wr",  32'(mem_wr_v[d]), 32'(exp_wr));
                chk(d, "mem_din", mdin_v[d],        exp_wr ? wd : 32'd0);
                if (exp_wr)
                    for (int b = 0; b < 4; b++) if (be[b]) ref_mem[d][a[11:2]][b*8 +: 8] = wd[b*8 +: 8];
            end else begin
                chk(d, "mem_wr_once", 32'(mem_wr_v[d]), 0);
                chk(d, "mem_din_late", mdin_v[d], 0);
            end
            if (k == abort_k) begin
                sel_v[d] = 1'b0; en_v[d] = 1'b0;
                @(posedge clk); #1;
                chk(d, "abort_ready", 32'(ready_v[d]), 0);
                chk(d, "abort_be",    32'(mbe_v[d]),   0);
                chk(d, "abort_addr",  maddr_v[d],      0);
                return;
            end
            @(posedge clk); #1;
        end
        chk(d, "resp_ready",  32'(ready_v[d]),  1);
        chk(d, "resp_slverr", 32'(slverr_v[d]), 32'(err));
        chk(d, "resp_rdata",  rdata_v[d],       exp_rd);
        chk(d, "resp_mem_wr", 32'(mem_wr_v[d]), 0);
        chk(d, "resp_be",     32'(mbe_v[d]),    err ? 32'd0 : 32'(be));
        chk(d, "resp_addr",   maddr_v[d],       {a[31:2], 2'b00});
        sel_v[d] = 1'b0; en_v[d] = 1'b0;
        @(posedge clk); #1;
        chk(d, "idle_ready", 32'(ready_v[d]), 0);
        chk(d, "idle_be",    32'(mbe_v[d]),   0);
        chk(d, "idle_addr",  maddr_v[d],      0);
        chk(d, "idle_rdata", rdata_v[d],      0);
    endtask

    initial begin
        bit [1:0]  s;
        bit [31:0] a;
        bit        wr;
        int        ab;

        for (int d = 0; d < 2; d++) begin
            sel_v[d] = 1'b0; en_v[d] = 1'b0; wr_v[d] = 1'b0;
            strb_v[d] = '0; addr_v[d] = '0; wdata_v[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk_zero(0, "reset");
        chk_zero(1, "reset");
        mem_clr = 1'b0;
        rst_n   = 1'b1;
        @(posedge clk); #1;

        // Word write, byte read from the preloaded word, aligned word/half accesses.
        xfer(0, 1'b1, 2'b10, 32'h20, 32'h11223344, 0);
        xfer(0, 1'b0, 2'b00, 32'h22, 32'h0, 0);
        xfer(0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 0);
        xfer(0, 1'b0, 2'b01, 32'h12, 32'h0, 0);
        xfer(0, 1'b1, 2'b00, 32'h13, 32'h00000077, 0);
        xfer(0, 1'b0, 2'b10, 32'h10, 32'h0, 0);

        // Error responses: misaligned half, out of range, reserved size, misaligned word.
        xfer(0, 1'b0, 2'b01, 32'h05, 32'h0, 0);
        xfer(0, 1'b1, 2'b10, 32'h1000, 32'hCAFEF00D, 0);
        xfer(0, 1'b0, 2'b11, 32'h30, 32'h0, 0);
        xfer(0, 1'b1, 2'b10, 32'h12, 32'h12345678, 0);
        xfer(0, 1'b0, 2'b10, 32'h10, 32'h0, 0);

        // Abort in the second ACCESS cycle; the issued write stands and the next setup is taken at once.
        xfer(0, 1'b1, 2'b10, 32'h50, 32'h55AA55AA, 2);
        xfer(0, 1'b0, 2'b10, 32'h50, 32'h0, 0);

        // Reset in the second ACCESS cycle.
        sel_v[0] = 1'b1; en_v[0] = 1'b0; wr_v[0] = 1'b1;
        strb_v[0] = 2'b10; addr_v[0] = 32'h40; wdata_v[0] = 32'h0BADF00D;
        @(posedge clk); #1;
        en_v[0] = 1'b1;
        chk(0, "rst_mem_wr", 32'(mem_wr_v[0]), 1);
        ref_mem[0][16] = 32'h0BADF00D;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_zero(0, "midrst");
        rst_n = 1'b1; sel_v[0] = 1'b0; en_v[0] = 1'b0;
        @(posedge clk); #1;
        chk_zero(0, "postrst");
        xfer(0, 1'b0, 2'b10, 32'h40, 32'h0, 0);

        // Randomized transfers against the reference model.
        for (int i = 0; i < 40; i++) begin
            s  = 2'($urandom_range(0, 3));
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = $urandom | 32'h1000;
            else a = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
            xfer(0, wr, s, a, $urandom, ab);
        end

        // Long wait states: back-to-back write then read, ready 16 cycles after setup.
        xfer(1, 1'b1, 2'b10, 32'h0, 32'hA5A5A5A5, 0);
        xfer(1, 1'b0, 2'b10, 32'h0, 32'h0, 0);
        xfer(1, 1'b1, 2'b01, 32'h6, 32'h3C3C0000, 7);
        xfer(1, 1'b0, 2'b10, 32'h4, 32'h0, 0);
        for (int i = 0; i < 6; i++) begin
            s  = 2'($urandom_range(0, 2));
            wr = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 3) * 4 + $urandom_range(0, 3));
            xfer(1, wr, s, a, $urandom, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
